rep3_majority_decoder: RTL and testbench

Receive-side decoder for the ECE272 demo link. It takes a 12-bit received frame that carries a 4-bit payload as a triple-repetition code. Each payload bit is recovered by a 2-of-3 majority vote, which corrects any single flipped bit per group. It sits between the receiver's frame capture and the payload consumer, and registers its result on the single system clock.

---
 rtl/rep3_pkg.sv | 22 ++
 rtl/rep3_majority_decoder_majority3.sv | 14 +
 rtl/rep3_majority_decoder.sv | 46 ++++
 tb/tb_rep3_majority_decoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rep3_pkg.sv
// Shared constants and frame helpers for the triple-repetition receive decoder.
// Pure declarations; no timing or flow control of its own.
package rep3_pkg;

  localparam int DATA_W  = 4;
  localparam int REP     = 3;
  localparam int FRAME_W = DATA_W * REP;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [REP-1:0]     group_t;
  typedef logic [DATA_W-1:0]  payload_t;

  // Repetition group k occupies frame[3k+2:3k].
  function automatic group_t frame_group(input frame_t frame, input int k);
    group_t g;
    for (int i = 0; i < REP; i++) begin
      g[i] = frame[k*REP + i];
    end
    return g;
  endfunction

endpackage

// File: rtl/rep3_majority_decoder_majority3.sv
// 2-of-3 majority voter with a non-unanimous flag; purely combinational.
// Zero latency, no flow control.
module majority3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y,
  output logic err
);

  assign y   = (a & b) | (a & c) | (b & c);
  assign err = ~((a == b) && (b == c));

endmodule

// File: rtl/rep3_majority_decoder.sv
// Triple-repetition frame decoder: per-group majority vote plus correction flags.
// One-cycle registered latency, one frame per clock, no backpressure.
module rep3_majority_decoder #(
  parameter int DATA_W = 4,
  parameter int REP    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W*REP-1:0] data_in,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     data_out,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     corrected
);

  import rep3_pkg::*;

  logic [DATA_W-1:0] vote;
  logic [DATA_W-1:0] vote_err;

  for (genvar k = 0; k < DATA_W; k++) begin : g_vote
    majority3 u_maj (
      .a   (data_in[k*REP + 2]),
      .b   (data_in[k*REP + 1]),
      .c   (data_in[k*REP + 0]),
      .y   (vote[k]),
      .err (vote_err[k])
    );
  end

  // Outputs hold between accepted frames; the strobe marks only the load cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      corrected <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out  <= vote;
        corrected <= vote_err;
      end
    end
  end

endmodule

// File: tb/tb_rep3_majority_decoder.sv
// Directed, exhaustive and random checks of the repetition decoder
// against an arithmetic vote-count model.
module tb_rep3_majority_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic        in_valid;
  logic [3:0]  data_out;
  logic        out_valid;
  logic [3:0]  corrected;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_data;
  logic [3:0] exp_corr;

  rep3_majority_decoder #(.DATA_W(4), .REP(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid),
    .corrected (corrected)
  );

  always #5 clk = ~clk;

  // Counts ones per group: 2 or more decodes to 1; anything but 0 or 3 was corrected.
  function automatic logic [7:0] model(input logic [11:0] f);
    logic [7:0] r;
    int cnt;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      cnt = int'(f[3*k]) + int'(f[3*k+1]) + int'(f[3*k+2]);
      r[k]     = (cnt >= 2);
      r[4 + k] = (cnt != 0) && (cnt != 3);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [11:0] f, input logic v);
    logic [7:0] m;
    @(negedge clk);
    data_in  = f;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      m = model(f);
      exp_data = m[3:0];
      exp_corr = m[7:4];
    end
  endtask

  task automatic check_all(input string tag, input logic v);
    check({tag, ".data"}, data_out, exp_data);
    check({tag, ".corr"}, corrected, exp_corr);
    check({tag, ".valid"}, {3'b000, out_valid}, {3'b000, v});
  endtask

  initial begin
    logic [11:0] f;
    logic        v;

    rst      = 1'b1;
    data_in  = '0;
    in_valid = 1'b0;
    exp_data = '0;
    exp_corr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0);

    @(negedge clk);
    rst = 1'b0;

    step(12'b000011000000, 1'b1);
    check_all("plan1", 1'b1);
    check("plan1.lit_data", data_out, 4'b0100);
    check("plan1.lit_corr", corrected, 4'b0100);

    step(12'b000000110000, 1'b1);
    check("plan2.lit_data", data_out, 4'b0010);
    check("plan2.lit_corr", corrected, 4'b0010);

    step(12'b111111111111, 1'b1);
    check("plan3.lit_data", data_out, 4'b1111);
    check("plan3.lit_corr", corrected, 4'b0000);

    step(12'b000000000000, 1'b1);
    check("plan4.lit_data", data_out, 4'b0000);
    check("plan4.lit_corr", corrected, 4'b0000);

    step(12'b110101011001, 1'b1);
    check("plan5.lit_data", data_out, 4'b1110);
    check("plan5.lit_corr", corrected, 4'b1111);

    // Hold while data_in wanders with in_valid low.
    step(12'b000011000000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(12'($urandom), 1'b0);
      check("hold.lit_data", data_out, 4'b0100);
      check_all("hold", 1'b0);
    end

    // Back-to-back frames, one strobe each.
    for (int i = 0; i < 6; i++) begin
      step(12'($urandom), 1'b1);
      check_all("b2b", 1'b1);
    end
    step(12'h000, 1'b0);
    check_all("b2b_end", 1'b0);

    // Asynchronous reset mid-stream.
    step(12'hFFF, 1'b1);
    check("pre_rst.lit_data", data_out, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    exp_data = '0;
    exp_corr = '0;
    check_all("async_rst", 1'b0);
    @(negedge clk);
    data_in  = 12'hFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_discard", 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(12'b000000111000, 1'b0);
    check_all("post_rst_idle", 1'b0);
    step(12'b000000111000, 1'b1);
    check_all("post_rst_first", 1'b1);
    check("post_rst.lit_data", data_out, 4'b0010);

    // Every possible frame, streamed back to back.
    for (int i = 0; i < 4096; i++) begin
      step(12'(i), 1'b1);
      check("exh.data", data_out, exp_data);
      check("exh.corr", corrected, exp_corr);
      check("exh.valid", {3'b000, out_valid}, 4'b0001);
    end

    // Random frames with random gaps.
    for (int i = 0; i < 300; i++) begin
      f = 12'($urandom);
      v = 1'($urandom_range(0, 1));
      step(f, v);
      check_all("rand", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
